// File: rtl/sdram_scan_dma_pkg.sv
// -----------------------------------------------------------------------------
// sdram_dma_pkg
// Shared types and constants for the SDRAM scan-out DMA master.
//   dma_state_t : control FSM states
//   WORD_BYTES  : byte stride between consecutive 16-bit words
//   MEM_WE_READ : bridge we_i encoding that selects a read access
// -----------------------------------------------------------------------------
package sdram_dma_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_ACC,
    WAIT_DONE,
    DONE
  } dma_state_t;

  localparam logic [31:0] WORD_BYTES  = 32'd2;
  localparam logic        MEM_WE_READ = 1'b1;

endpackage

// File: rtl/sdram_scan_dma_fifo.sv
// -----------------------------------------------------------------------------
// sdram_scan_fifo
// Synchronous first-word-fallthrough FIFO buffering fetched SDRAM words.
//   clk_i, rst_i  : clock, asynchronous active-high reset
//   push_i        : write push_data_i (accepted when not full, or full and popping)
//   push_data_i   : word to store
//   pop_i         : consume the head word (ignored when empty)
//   pop_data_o    : head word, valid whenever empty_o is low
//   level_o       : occupancy, 0..DEPTH
//   empty_o/full_o: occupancy flags
// DEPTH must be a power of two, at least 2.
// -----------------------------------------------------------------------------
module sdram_scan_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [DATA_W-1:0]      push_data_i,
  input  logic                   pop_i,
  output logic [DATA_W-1:0]      pop_data_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   empty_o,
  output logic                   full_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    level_q, level_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              push_en, pop_en;

  assign empty_o    = (level_q == '0);
  assign full_o     = (level_q == (PTR_W+1)'(DEPTH));
  assign level_o    = level_q;
  assign pop_data_o = mem_q[rd_ptr_q];

  assign pop_en  = pop_i && !empty_o;
  // A simultaneous pop frees the slot being written, so a full FIFO may push then.
  assign push_en = push_i && (!full_o || pop_en);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_en)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_en, pop_en})
      2'b10:   level_d = level_q + (PTR_W+1)'(1);
      2'b01:   level_d = level_q - (PTR_W+1)'(1);
      default: level_d = level_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // NOTE: the storage array has no reset; the pointers and level alone define which entries are valid.
  always_ff @(posedge clk_i) begin
    if (push_en) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/sdram_scan_dma.sv
// -----------------------------------------------------------------------------
// sdram_scan_dma
// Read-only DMA master: fetches a linear run of 16-bit words through the
// SDRAM bridge (one outstanding stb/cyc access) into a local FWFT FIFO that a
// streaming consumer drains with valid/ready.
//   clk_i, rst_i        : clock, asynchronous active-high reset
//   start_i             : start pulse, sampled only while idle
//   abort_i             : stop issuing new accesses (the one in flight completes)
//   base_addr_i, len_i  : first byte address (bit 0 ignored), length in words
//   busy_o, done_o      : transfer active, one-cycle completion pulse
//   mem_stb_o, mem_we_o, mem_addr_o, mem_cyc_i, mem_dat_i : bridge side
//   px_valid_o, px_data_o, px_ready_i : consumer side
//   level_o             : FIFO occupancy
// -----------------------------------------------------------------------------
module sdram_scan_dma
  import sdram_dma_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int LEN_W      = 16,
  parameter int DATA_W     = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        start_i,
  input  logic                        abort_i,
  input  logic [31:0]                 base_addr_i,
  input  logic [LEN_W-1:0]            len_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        mem_stb_o,
  output logic                        mem_we_o,
  output logic [31:0]                 mem_addr_o,
  input  logic                        mem_cyc_i,
  input  logic [DATA_W-1:0]           mem_dat_i,
  output logic                        px_valid_o,
  output logic [DATA_W-1:0]           px_data_o,
  input  logic                        px_ready_i,
  output logic [$clog2(FIFO_DEPTH):0] level_o
);

  dma_state_t       state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             stb_q, stb_d;
  logic             push;
  logic             fifo_empty, fifo_full;

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign mem_stb_o  = stb_q;
  assign mem_addr_o = addr_q;
  assign mem_we_o   = MEM_WE_READ;
  assign px_valid_o = !fifo_empty;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    busy_d  = busy_q;
    stb_d   = stb_q;
    done_d  = 1'b0;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          addr_d  = {base_addr_i[31:1], 1'b0};
          rem_d   = len_i;
          busy_d  = 1'b1;
          state_d = (len_i == '0) ? DONE : REQ;
        end
      end
      REQ: begin
        if (abort_i) begin
          state_d = DONE;
        end else if (!fifo_full) begin
          // Issue only with a free slot, so the later push can never overflow.
          stb_d   = 1'b1;
          state_d = WAIT_ACC;
        end
      end
      WAIT_ACC: begin
        if (mem_cyc_i) begin
          stb_d   = 1'b0;
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        // Falling cyc marks the bridge's data beat.
        if (!mem_cyc_i) begin
          push    = 1'b1;
          addr_d  = addr_q + WORD_BYTES;
          rem_d   = rem_q - LEN_W'(1);
          state_d = (rem_q == LEN_W'(1) || abort_i) ? DONE : REQ;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      stb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      stb_q   <= stb_d;
    end
  end

  sdram_scan_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DATA_W(DATA_W)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (push),
    .push_data_i(mem_dat_i),
    .pop_i      (px_ready_i),
    .pop_data_o (px_data_o),
    .level_o    (level_o),
    .empty_o    (fifo_empty),
    .full_o     (fifo_full)
  );

endmodule

// File: doc/sdram_scan_dma.md
Name: sdram_scan_dma

Overview:
- Read-only DMA master that sits directly upstream of the Wishbone-style SDRAM bridge.
- Once started, it fetches a linear run of 16-bit words from SDRAM, one access at a time over the bridge's stb/cyc handshake.
- Fetched words go into a local FIFO, which a streaming consumer (pixel pipeline, audio DAC, etc.) drains with a valid/ready handshake.

Parameters:
- FIFO_DEPTH, 16, FIFO entries; must be a power of two, at least 2.
- LEN_W, 16, width of the transfer length in words.
- DATA_W, 16, memory word width; fixed by the bridge.

Ports:
- clk_i  in  1  single clock, shared with the bridge
- rst_i  in  1  asynchronous, active-high reset
- start_i  in  1  one-cycle start pulse; sampled only in IDLE
- abort_i  in  1  level; stop issuing new requests
- base_addr_i  in  32  byte address of first word; bit 0 ignored (forced 0)
- len_i  in  LEN_W  number of 16-bit words to fetch
- busy_o  out  1  high from accepted start until DONE exits
- done_o  out  1  one-cycle pulse on completion or abort
- mem_stb_o  out  1  request strobe to bridge stb_i
- mem_we_o  out  1  to bridge we_i; constant 1 (bridge encoding: we=1 selects read)
- mem_addr_o  out  32  byte address to bridge addr_i
- mem_cyc_i  in  1  bridge cyc_o
- mem_dat_i  in  DATA_W  bridge dat_o
- px_valid_o  out  1  FIFO not empty
- px_data_o  out  DATA_W  FIFO head word
- px_ready_i  in  1  consumer pop
- level_o  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset values (async on rst_i high): state IDLE; busy_o=0, done_o=0, mem_stb_o=0, mem_addr_o=0, FIFO empty, px_valid_o=0, level_o=0. mem_we_o=1 at all times.
- Reset mid-transfer: everything above clears immediately. Any in-flight bridge data is dropped. The bridge is reset by the same rst_i.
- FSM states:
  - IDLE: on start_i, latch addr={base_addr_i[31:1],1'b0} and remaining=len_i, set busy_o=1. If len_i==0, go to DONE; otherwise go to REQ.
  - REQ: if abort_i, go to DONE. Otherwise, when level_o < FIFO_DEPTH, drive mem_stb_o=1 and mem_addr_o=addr, then go to WAIT_ACC.
  - WAIT_ACC: hold mem_stb_o and mem_addr_o stable until mem_cyc_i==1 is sampled. On that edge drop mem_stb_o and go to WAIT_DONE.
  - WAIT_DONE: wait for mem_cyc_i==0. In that cycle:
    - push mem_dat_i into the FIFO;
    - addr += 2 (wraps modulo 2^32);
    - remaining -= 1;
    - if remaining reaches 0 or abort_i is high, go to DONE; otherwise go to REQ.
  - DONE: done_o=1 for exactly one cycle, busy_o=0 on exit, return to IDLE.
- Outstanding requests: at most one. The push in WAIT_DONE can never overflow, because REQ only issues when the FIFO has a free slot.
- Latency: from start_i to mem_stb_o is 2 cycles. Between a completion and the next mem_stb_o is 1 cycle (REQ), provided the FIFO has room.
- abort_i: never cancels an accepted access. The outstanding word is still pushed; words already in the FIFO remain poppable.
- FIFO:
  - First-word-fallthrough: px_data_o is valid whenever px_valid_o is high.
  - A pop occurs when px_valid_o && px_ready_i.
  - Push and pop in the same cycle: level is unchanged, data order is preserved. This holds when full as well, but a full FIFO never receives a push.
  - Pop when empty is ignored.
- start_i while busy_o=1 is ignored.
- The FIFO is not cleared by start_i; a new transfer appends behind any residual words.

Decomposition:
- Package sdram_dma_pkg: state enum (IDLE, REQ, WAIT_ACC, WAIT_DONE, DONE), constant WORD_BYTES=2, constant MEM_WE_READ=1'b1.
- Sub-module sdram_scan_fifo: synchronous FWFT FIFO with parameters DEPTH and DATA_W, async active-high reset, ports push/pop/data/level/empty/full. Instantiated once.

Test Plan:
- Basic fetch: base=0x100, len=4, bridge model returns 0xA000+word index, px_ready=1 → mem_addr_o sequence 0x100/0x102/0x104/0x106; px_data sequence A080/A081/A082/A083 (0x100>>1 = 0x80); exactly one done_o pulse; busy_o low afterwards.
- Backpressure: FIFO_DEPTH=4, len=10, px_ready=0 → exactly 4 requests issued, then mem_stb_o stays low with level_o=4. Raising px_ready resumes fetching; all 10 words arrive in order.
- Zero length and odd base: len=0 gives done_o two cycles after start_i with no mem_stb_o. Base=0x201, len=1 gives mem_addr_o=0x200.
- Abort: len=8, assert abort_i during the 3rd access's WAIT_DONE → the 3rd word is pushed, no 4th request, done_o pulses, level_o=3.
- Reset mid-op: assert rst_i while in WAIT_ACC with level_o=2 → all outputs drop immediately to reset values. After release, a new transfer (base 0x0, len 2) completes normally.
- Simultaneous push/pop and wrap: len=40, FIFO_DEPTH=16, px_ready toggling every cycle → no data loss or reordering; level_o never exceeds 16; read pointers wrap multiple times.
